// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory-port arbiter.
// Latency: n/a (constants, types and a helper only).
// Backpressure: n/a.
package mem_arbiter_pkg;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int STRB_W   = 4;
  localparam int STARVE_W = 3;

  // Owner IDs stored in the outstanding-transaction FIFO
  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD_I = 2'd1,
    ST_HOLD_D = 2'd2
  } arb_state_e;

  // HOLD state that freezes the grant on the given owner
  function automatic arb_state_e hold_state(input logic own);
    return (own == OWN_DATA) ? ST_HOLD_D : ST_HOLD_I;
  endfunction

endpackage

// File: rtl/arb_owner_fifo.sv
// Owner-ID FIFO: remembers which requester owns each accepted memory transaction.
// Latency: push visible at head the cycle after write; pop takes effect at the next edge.
// Backpressure: full/empty flags; push while full and pop while empty are ignored.
module arb_owner_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Next-state for storage, pointers and occupancy; push+pop leaves count unchanged
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_id;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO state registers; reset discards every outstanding ID
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and EX/ME requests onto one memory port, routing in-order returns back.
// Latency: zero-cycle request pass-through and accept; data_ok routed in the same cycle as mem_data_ok.
// Backpressure: mem_addr_ok stalls the granted side (grant frozen); OUTSTANDING full blocks mem_req.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int OUTSTANDING  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              resetn,
  // fetch side
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  // EX/ME side
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [STRB_W-1:0] data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  // shared memory port
  output logic              mem_req,
  output logic              mem_wr,
  output logic [STRB_W-1:0] mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err_spurious
);

  arb_state_e          state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                err_q, err_d;
  logic                grant;
  logic                sel_req;
  logic                accept;
  logic                rsp_vld;
  logic                fifo_full, fifo_empty, fifo_head;

  // Owner selection: arbitrate in IDLE, keep the stalled owner while in HOLD
  always_comb begin
    grant = OWN_INST;
    case (state_q)
      ST_HOLD_I: grant = OWN_INST;
      ST_HOLD_D: grant = OWN_DATA;
      default: begin
        if (data_req && ((int'(starve_q) < STARVE_LIMIT) || !inst_req)) grant = OWN_DATA;
        else                                                           grant = OWN_INST;
      end
    endcase
  end

  // Request path muxed from the granted owner; fetch side never writes.
  // resetn gating keeps mem_req (and so every addr_ok) low while reset is held.
  assign sel_req   = (grant == OWN_DATA) ? data_req : inst_req;
  assign mem_req   = resetn && sel_req && !fifo_full;
  assign accept    = mem_req && mem_addr_ok;
  assign mem_wr    = (grant == OWN_DATA) && data_wr;
  assign mem_wstrb = (grant == OWN_DATA) ? data_wstrb : '0;
  assign mem_addr  = (grant == OWN_DATA) ? data_addr  : inst_addr;
  assign mem_wdata = (grant == OWN_DATA) ? data_wdata : '0;

  assign inst_addr_ok = accept && (grant == OWN_INST);
  assign data_addr_ok = accept && (grant == OWN_DATA);

  // Returns go to the owner at the FIFO head; returns with nothing outstanding are dropped
  assign rsp_vld      = mem_data_ok && !fifo_empty;
  assign inst_data_ok = rsp_vld && (fifo_head == OWN_INST);
  assign data_data_ok = rsp_vld && (fifo_head == OWN_DATA);
  assign inst_rdata   = inst_data_ok ? mem_rdata : '0;
  assign data_rdata   = data_data_ok ? mem_rdata : '0;
  assign err_spurious = err_q;

  arb_owner_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_owner_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push    (accept),
    .push_id (grant),
    .pop     (rsp_vld),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head)
  );

  // Grant FSM next state: enter HOLD when the granted request is stalled, leave on accept
  always_comb begin
    state_d = state_q;
    if (!fifo_full) begin
      case (state_q)
        ST_IDLE:              if (mem_req && !mem_addr_ok) state_d = hold_state(grant);
        ST_HOLD_I, ST_HOLD_D: if (accept)                  state_d = ST_IDLE;
        default:                                           state_d = ST_IDLE;
      endcase
    end
  end

  // Grant FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Starvation count of data wins over a waiting fetch, plus the sticky spurious-return flag
  always_comb begin
    starve_d = starve_q;
    if (!inst_req || (accept && grant == OWN_INST)) begin
      starve_d = '0;
    end else if (accept && grant == OWN_DATA && starve_q != '1) begin
      starve_d = starve_q + STARVE_W'(1);
    end
    err_d = err_q || (mem_data_ok && fifo_empty);
  end

  // Starve counter and error flag registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_q <= '0;
      err_q    <= 1'b0;
    end else begin
      starve_q <= starve_d;
      err_q    <= err_d;
    end
  end

endmodule
